communication_receiver: RTL and testbench

Serial receive front end on the FPGA2 side of the two-board link. It samples the serial line `rec_data` on rising edges of the transmitter's bit clock `freq`, which arrives alongside the data. It assembles 10-bit frames (start, 8 data bits LSB first, stop) and presents the last good byte on `out_data`. The `en` output tells FPGA1 whether it may send the next frame; the parent maps `out_data` to a speed level.

---
 rtl/communication_receiver.sv | 141 ++++++++++++++
 tb/tb_communication_receiver.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/communication_receiver.sv
// Serial receive front end: samples rec_data on rising edges of the
// transmitter bit clock freq, assembles start/8 data/stop frames (LSB first)
// and holds the last correctly framed byte on out_data.
//
// state | meaning
// IDLE  | waiting for a start bit; en = rec_en
// DATA  | shifting in payload bits, timeout counter running
// STOP  | waiting for the stop bit, timeout counter running
module communication_receiver #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              rec_data,
    input  logic              freq,
    input  logic              rec_en,
    output logic [DATA_W-1:0] out_data,
    output logic              en
);

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state;
    logic              data_m;
    logic              data_s;
    logic              freq_m;
    logic              freq_s;
    logic              freq_d;
    logic [DATA_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              edge_evt;
    logic              tmo_hit;

    // Two-flop synchronisers for both serial inputs plus a delay flop on freq
    // for rising-edge detection; data and clock see identical latency.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            data_m <= 1'b1;
            data_s <= 1'b1;
            freq_m <= 1'b0;
            freq_s <= 1'b0;
            freq_d <= 1'b0;
        end else begin
            data_m <= rec_data;
            data_s <= data_m;
            freq_m <= freq;
            freq_s <= freq_m;
            freq_d <= freq_s;
        end
    end

    assign edge_evt = freq_s & ~freq_d;
    assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT));

    // Frame FSM with registered out_data and en; en tracks the next state so
    // it changes in the same cycle as the state register.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            out_data  <= '0;
            en        <= 1'b0;
        end else if (!rec_en) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tmo_cnt <= '0;
            en      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    bit_cnt <= '0;
                    if (edge_evt && !data_s) begin
                        state <= DATA;
                        en    <= 1'b0;
                    end else begin
                        en <= 1'b1;
                    end
                end
                DATA: begin
                    if (edge_evt) begin
                        shift_reg <= {data_s, shift_reg[DATA_W-1:1]};
                        tmo_cnt   <= '0;
                        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                        en <= 1'b0;
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                        en      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                        en      <= 1'b0;
                    end
                end
                STOP: begin
                    if (edge_evt) begin
                        if (data_s) begin
                            out_data <= shift_reg;
                        end
                        state   <= IDLE;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                        en      <= 1'b1;
                    end else if (tmo_hit) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        tmo_cnt <= '0;
                        en      <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                        en      <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                    en      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_communication_receiver.sv
// Directed and randomized frame stimulus for communication_receiver, checked
// against a frame-level model holding the last good byte.
module tb_communication_receiver;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 6;

    logic              clk2 = 1'b0;
    logic              rst = 1'b1;
    logic              rec_data = 1'b1;
    logic              freq = 1'b0;
    logic              rec_en = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              en;

    int tests = 0;
    int failed = 0;
    logic [DATA_W-1:0] exp_out = '0;

    communication_receiver #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk2(clk2),
        .rst(rst),
        .rec_data(rec_data),
        .freq(freq),
        .rec_en(rec_en),
        .out_data(out_data),
        .en(en)
    );

    always #5 clk2 = ~clk2;

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk2);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One bit period: data set during freq low, rising edge mid-period.
    task automatic send_bit(input logic b);
        rec_data = b;
        clk_wait(HALF);
        freq = 1'b1;
        clk_wait(HALF);
        freq = 1'b0;
    endtask

    // Full frame; model update: only a 1 stop bit with rec_en high commits.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_bit, input string tag);
        logic [DATA_W-1:0] v;
        v = d;
        send_bit(1'b0);
        check({tag, "_en_low_after_start"}, {31'd0, en}, 32'd0);
        for (int i = 0; i < DATA_W; i++) send_bit(v[i]);
        send_bit(stop_bit);
        if (stop_bit && rec_en) exp_out = d;
        rec_data = 1'b1;
        check({tag, "_out"}, {24'd0, out_data}, {24'd0, exp_out});
        check({tag, "_en_after_stop"}, {31'd0, en}, {31'd0, rec_en});
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] rb;
        logic              sb;

        // Reset state
        clk_wait(3);
        check("reset_out", {24'd0, out_data}, 32'd0);
        check("reset_en", {31'd0, en}, 32'd0);
        rst = 1'b0;
        clk_wait(1);
        check("en_after_release", {31'd0, en}, 32'd1);
        clk_wait(4);

        // Reset mid-frame after 4 data bits
        v = 8'hA7;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(v[i]);
        check("midframe_en", {31'd0, en}, 32'd0);
        rst = 1'b1;
        #1;
        exp_out = '0;
        check("midframe_rst_out", {24'd0, out_data}, 32'd0);
        check("midframe_rst_en", {31'd0, en}, 32'd0);
        rec_data = 1'b1;
        clk_wait(3);
        rst = 1'b0;
        clk_wait(1);
        check("midframe_release_en", {31'd0, en}, 32'd1);
        send_frame(8'h3C, 1'b1, "post_rst_3c");

        // Good frame and back-to-back frames
        send_frame(8'h5A, 1'b1, "good_5a");
        send_frame(8'h1E, 1'b1, "b2b_1e");
        send_frame(8'hB4, 1'b1, "b2b_b4");

        // Framing error, then recovery
        send_frame(8'hFF, 1'b0, "frame_err_ff");
        send_frame(8'h00, 1'b1, "after_err_00");

        // Timeout after 3 data bits
        v = 8'h6D;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(v[i]);
        check("tmo_en_busy", {31'd0, en}, 32'd0);
        clk_wait(TIMEOUT + 20);
        check("tmo_en", {31'd0, en}, 32'd1);
        check("tmo_out", {24'd0, out_data}, {24'd0, exp_out});
        send_frame(8'hC3, 1'b1, "after_tmo_c3");

        // Disable mid-frame
        v = 8'h42;
        send_bit(1'b0);
        for (int i = 0; i < 2; i++) send_bit(v[i]);
        rec_en = 1'b0;
        clk_wait(1);
        check("dis_en", {31'd0, en}, 32'd0);
        for (int i = 2; i < DATA_W; i++) send_bit(v[i]);
        send_bit(1'b1);
        v = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) send_bit(v[i]);
        send_bit(1'b1);
        check("dis_out", {24'd0, out_data}, {24'd0, exp_out});
        check("dis_en_held", {31'd0, en}, 32'd0);
        rec_en = 1'b1;
        clk_wait(1);
        check("reen_en", {31'd0, en}, 32'd1);
        send_frame(8'h96, 1'b1, "reen_96");

        // Randomized frames with occasional framing errors and idle gaps
        for (int n = 0; n < 24; n++) begin
            rb = DATA_W'($urandom_range(0, 255));
            sb = ($urandom_range(0, 3) != 0);
            send_frame(rb, sb, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) send_bit(1'b1);
                check($sformatf("rnd%0d_idle_out", n), {24'd0, out_data}, {24'd0, exp_out});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
